// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Handshake and data bundle for the sequential divider.
//   master : drives i_start, i_signed_op, i_a (dividend), i_b (divisor);
//            observes o_q, o_r, o_busy, o_done, o_dz, o_v
//   slave  : the divider itself (directions mirrored)
// ----------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int WIDTH = 18
);
   logic             i_start;
   logic             i_signed_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic [WIDTH-1:0] o_q;
   logic [WIDTH-1:0] o_r;
   logic             o_busy;
   logic             o_done;
   logic             o_dz;
   logic             o_v;

   modport master (
      output i_start, i_signed_op, i_a, i_b,
      input  o_q, o_r, o_busy, o_done, o_dz, o_v
   );

   modport slave (
      input  i_start, i_signed_op, i_a, i_b,
      output o_q, o_r, o_busy, o_done, o_dz, o_v
   );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring integer divider, one quotient bit per cycle.
// Signed (truncating toward zero, remainder follows dividend) and unsigned
// modes; divide-by-zero and most-negative/-1 overflow finish immediately
// with fixed results and a flag.
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   io (slave)   : i_start/i_signed_op/i_a/i_b in; o_q/o_r/o_busy/o_done/
//                  o_dz/o_v out, all driven from flops
// ----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 18
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   seq_divider_if.slave io
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   // control / output registers
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign_a;
   logic             r_sign_b;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_busy;
   logic             r_done;
   logic             r_dz;
   logic             r_v;

   // iteration datapath registers
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;

   logic             w_accept;
   logic             w_sign_a;
   logic             w_sign_b;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_trial;
   logic             w_trial_neg;

   // Two's-complement negation in WIDTH bits.
   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] s;
      s = $signed(v);
      s = -s;
      return s;
   endfunction

   // Magnitude taken in WIDTH+1 bits so the most-negative value does not wrap;
   // the result always fits an unsigned WIDTH-bit field.
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
      logic signed [WIDTH:0] ext;
      ext = neg ? $signed({v[WIDTH-1], v}) : $signed({1'b0, v});
      if (neg) ext = -ext;
      return ext[WIDTH-1:0];
   endfunction

   assign w_accept = (r_state == IDLE) && io.i_start;
   assign w_sign_a = io.i_a[WIDTH-1] & io.i_signed_op;
   assign w_sign_b = io.i_b[WIDTH-1] & io.i_signed_op;

   // Shifted partial remainder needs one extra bit; the trial difference's top
   // bit is a valid borrow because rem_shifted < 2*divisor.
   assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
   assign w_trial     = w_rem_sh - {1'b0, r_div};
   assign w_trial_neg = w_trial[WIDTH];

   // ---- iteration datapath: load on accept, one restoring step per RUN cycle
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_quo <= f_mag(io.i_a, w_sign_a);
         r_div <= f_mag(io.i_b, w_sign_b);
         r_rem <= '0;
      end else if (r_state == RUN) begin
         r_rem <= w_trial_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
         r_quo <= {r_quo[WIDTH-2:0], ~w_trial_neg};
      end
   end

   // ---- control FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_q      <= '0;
         r_r      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
         r_v      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (io.i_start) begin
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_dz     <= 1'b0;
                  r_v      <= 1'b0;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  if (io.i_b == '0) begin
                     r_state <= DONE;
                     r_q     <= ALL_ONES;
                     r_r     <= io.i_a;
                     r_dz    <= 1'b1;
                     r_done  <= 1'b1;
                  end else if (io.i_signed_op && io.i_a == MOST_NEG && io.i_b == ALL_ONES) begin
                     r_state <= DONE;
                     r_q     <= io.i_a;
                     r_r     <= '0;
                     r_v     <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
            end
            FIX: begin
               r_q     <= (r_sign_a ^ r_sign_b) ? f_neg(r_quo) : r_quo;
               r_r     <= r_sign_a ? f_neg(r_rem) : r_rem;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io.o_q    = r_q;
   assign io.o_r    = r_r;
   assign io.o_busy = r_busy;
   assign io.o_done = r_done;
   assign io.o_dz   = r_dz;
   assign io.o_v    = r_v;

endmodule
